// File: rtl/mod_mult_interleaved.sv
// Interleaved shift-add-reduce modular multiplier: m_tdata = (a * b) mod m, one bit of a per cycle.
// Optional operand range checking is built when MOD_MULT_OPERAND_CHECK_EN is defined.
module mod_mult_interleaved #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_a_tdata,
  input  logic [WIDTH-1:0] s_b_tdata,
  input  logic [WIDTH-1:0] s_m_tdata,
  input  logic [TAG_W-1:0] s_tid,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic [WIDTH-1:0] m_tdata,
  output logic [TAG_W-1:0] m_tid,
  output logic             m_err,
  output logic             m_tvalid,
  input  logic             m_tready
);

  // state | meaning
  // IDLE  | waiting for a request beat, s_tready high
  // RUN   | processing one bit of a per cycle, MSB first
  // DONE  | result presented, waiting for downstream to accept

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_r, b_r, m_r;
  logic [TAG_W-1:0]   tid_r;
  logic [WIDTH+1:0]   p;
  logic [WIDTH+1:0]   m_ext, t_sum, t_red1, t_red2;
  logic [CW-1:0]      bit_cnt;
  logic               hs_in;

  assign s_tready = (state == IDLE) & ~rst;
  assign m_tvalid = (state == DONE);
  assign hs_in    = s_tvalid & s_tready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (hs_in) state_nxt = RUN;
      RUN:     if (bit_cnt == '0) state_nxt = DONE;
      DONE:    if (m_tready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Two conditional subtractions keep P below m since 2P + b < 3m.
  always_comb begin
    m_ext  = {2'b00, m_r};
    t_sum  = (p << 1) + (a_r[bit_cnt] ? {2'b00, b_r} : '0);
    t_red1 = (t_sum  >= m_ext) ? t_sum  - m_ext : t_sum;
    t_red2 = (t_red1 >= m_ext) ? t_red1 - m_ext : t_red1;
  end

`ifdef MOD_MULT_OPERAND_CHECK_EN
  logic err_r;
  logic m_err_r;
  assign m_err = m_err_r;
`else
  assign m_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      m_r     <= '0;
      tid_r   <= '0;
      p       <= '0;
      bit_cnt <= '0;
      m_tdata <= '0;
      m_tid   <= '0;
`ifdef MOD_MULT_OPERAND_CHECK_EN
      err_r   <= 1'b0;
      m_err_r <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (hs_in) begin
            a_r     <= s_a_tdata;
            b_r     <= s_b_tdata;
            m_r     <= s_m_tdata;
            tid_r   <= s_tid;
            p       <= '0;
            bit_cnt <= CW'(WIDTH - 1);
`ifdef MOD_MULT_OPERAND_CHECK_EN
            err_r   <= (s_m_tdata == '0) | (s_a_tdata >= s_m_tdata) |
                       (s_b_tdata >= s_m_tdata);
`endif
          end
        end
        RUN: begin
          p <= t_red2;
          if (bit_cnt == '0) begin
            m_tid <= tid_r;
`ifdef MOD_MULT_OPERAND_CHECK_EN
            m_tdata <= err_r ? '0 : t_red2[WIDTH-1:0];
            m_err_r <= err_r;
`else
            m_tdata <= t_red2[WIDTH-1:0];
`endif
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_mult_interleaved.sv
// Self-checking bench for mod_mult_interleaved: WIDTH=8 and WIDTH=64 instances against an arithmetic model.
module tb_mod_mult_interleaved;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] a8 = '0, b8 = '0, m8 = '0, d8;
  logic [3:0] tid8 = '0, mtid8;
  logic       sv8 = 1'b0, sr8, mv8, mr8 = 1'b0, err8;

  logic [63:0] a64 = '0, b64 = '0, m64 = '0, d64;
  logic [3:0]  tid64 = '0, mtid64;
  logic        sv64 = 1'b0, sr64, mv64, mr64 = 1'b0, err64;

  mod_mult_interleaved #(.WIDTH(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst(rst), .s_a_tdata(a8), .s_b_tdata(b8), .s_m_tdata(m8),
    .s_tid(tid8), .s_tvalid(sv8), .s_tready(sr8), .m_tdata(d8), .m_tid(mtid8),
    .m_err(err8), .m_tvalid(mv8), .m_tready(mr8));

  mod_mult_interleaved #(.WIDTH(64), .TAG_W(4)) dut64 (
    .clk(clk), .rst(rst), .s_a_tdata(a64), .s_b_tdata(b64), .s_m_tdata(m64),
    .s_tid(tid64), .s_tvalid(sv64), .s_tready(sr64), .m_tdata(d64), .m_tid(mtid64),
    .m_err(err64), .m_tvalid(mv64), .m_tready(mr64));

`ifdef MOD_MULT_OPERAND_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  function automatic logic [7:0] model8(input int a, input int b, input int m);
    return 8'((a * b) % m);
  endfunction

  function automatic logic [63:0] model64(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] m);
    logic [127:0] prod, r;
    prod = {64'b0, a} * {64'b0, b};
    r = prod % {64'b0, m};
    return r[63:0];
  endfunction

  // Presents a beat and returns at the negedge after the accepting edge.
  task automatic hs8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                     input logic [3:0] tid, output bit ok);
    bit rdy;
    @(negedge clk);
    a8 = a; b8 = b; m8 = m; tid8 = tid; sv8 = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      rdy = sr8;
      @(posedge clk);
      @(negedge clk);
      ok = rdy;
    end
    sv8 = 1'b0;
  endtask

  // Runs one request and leaves the result pending (m_tready low).
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                        input logic [3:0] tid, output logic [7:0] d, output logic [3:0] t,
                        output logic e, output int lat);
    bit ok;
    hs8(a, b, m, tid, ok);
    lat = -1;
    if (ok) begin
      for (int k = 1; k < 100; k++) begin
        @(posedge clk);
        @(negedge clk);
        if (mv8) begin lat = k; break; end
      end
    end
    d = d8; t = mtid8; e = err8;
  endtask

  task automatic release8(output logic sr_after, output logic mv_after);
    mr8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mr8 = 1'b0;
    sr_after = sr8;
    mv_after = mv8;
  endtask

  task automatic do_op64(input logic [63:0] a, input logic [63:0] b, input logic [63:0] m,
                         input logic [3:0] tid, output logic [63:0] d, output logic [3:0] t,
                         output int lat);
    bit ok, rdy;
    @(negedge clk);
    a64 = a; b64 = b; m64 = m; tid64 = tid; sv64 = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      rdy = sr64;
      @(posedge clk);
      @(negedge clk);
      ok = rdy;
    end
    sv64 = 1'b0;
    lat = -1;
    if (ok) begin
      for (int k = 1; k < 200; k++) begin
        @(posedge clk);
        @(negedge clk);
        if (mv64) begin lat = k; break; end
      end
    end
    d = d64; t = mtid64;
    mr64 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mr64 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (sr8 !== 1'b0) begin errors++; $display("FAIL reset_s_tready: got %b expected 0", sr8); end
    checks++; if (mv8 !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid: got %b expected 0", mv8); end
    checks++; if (d8 !== 8'd0 || mtid8 !== 4'd0 || err8 !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got data %0d tid %0d err %b expected 0 0 0", d8, mtid8, err8);
    end
    rst = 1'b0;
    #1;
    checks++; if (sr8 !== 1'b1 || sr64 !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b/%b expected 1/1", sr8, sr64);
    end
  endtask

  task automatic test_example;
    logic [7:0] d; logic [3:0] t; logic e, sra, mva; int lat;
    do_op8(8'd7, 8'd9, 8'd11, 4'd3, d, t, e, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL example_latency: got %0d expected 8", lat); end
    checks++; if (d !== 8'd8) begin errors++; $display("FAIL example_data: got %0d expected 8", d); end
    checks++; if (t !== 4'd3) begin errors++; $display("FAIL example_tid: got %0d expected 3", t); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL example_err: got %b expected 0", e); end
    release8(sra, mva);
    checks++; if (sra !== 1'b1 || mva !== 1'b0) begin
      errors++; $display("FAIL example_release: got ready %b valid %b expected 1 0", sra, mva);
    end
  endtask

  task automatic test_reset_mid;
    bit ok, seen;
    logic [7:0] d; logic [3:0] t; logic e, sra, mva; int lat;
    hs8(8'd100, 8'd77, 8'd201, 4'd9, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_handshake: got none expected accept"); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (mv8 !== 1'b0 || d8 !== 8'd0 || sr8 !== 1'b1) begin
      errors++; $display("FAIL rstmid_state: got valid %b data %0d ready %b expected 0 0 1", mv8, d8, sr8);
    end
    mr8 = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (mv8) seen = 1'b1;
    end
    mr8 = 1'b0;
    checks++; if (seen) begin errors++; $display("FAIL rstmid_no_result: got valid 1 expected 0"); end
    do_op8(8'd200, 8'd150, 8'd233, 4'd5, d, t, e, lat);
    checks++; if (d !== model8(200, 150, 233) || t !== 4'd5 || lat !== 8) begin
      errors++; $display("FAIL rstmid_followup: got data %0d tid %0d lat %0d expected %0d 5 8",
                         d, t, lat, model8(200, 150, 233));
    end
    release8(sra, mva);
  endtask

  task automatic test_backpressure;
    logic [7:0] d, exp; logic [3:0] t; logic e, sra, mva; int lat; bit bad;
    exp = model8(123, 45, 127);
    do_op8(8'd123, 8'd45, 8'd127, 4'd12, d, t, e, lat);
    checks++; if (d !== exp || t !== 4'd12 || lat !== 8) begin
      errors++; $display("FAIL bp_result: got data %0d tid %0d lat %0d expected %0d 12 8", d, t, lat, exp);
    end
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (mv8 !== 1'b1 || d8 !== exp || mtid8 !== 4'd12 || sr8 !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin
      errors++; $display("FAIL bp_hold: got valid %b data %0d tid %0d ready %b expected 1 %0d 12 0",
                         mv8, d8, mtid8, sr8, exp);
    end
    release8(sra, mva);
    checks++; if (sra !== 1'b1 || mva !== 1'b0) begin
      errors++; $display("FAIL bp_release: got ready %b valid %b expected 1 0", sra, mva);
    end
  endtask

  task automatic test_back_to_back;
    int av[3] = '{5, 10, 0};
    int bv[3] = '{6, 10, 200};
    int mv[3] = '{7, 13, 251};
    int hs_cyc[3];
    int idx = 0, n_out = 0, cyc = 0;
    bit hs, ov;
    logic [7:0] od; logic [3:0] ot;
    mr8 = 1'b1;
    @(negedge clk);
    a8 = 8'(av[0]); b8 = 8'(bv[0]); m8 = 8'(mv[0]); tid8 = 4'd1; sv8 = 1'b1;
    while (n_out < 3 && cyc < 100) begin
      hs = sv8 && sr8;
      ov = mv8 && mr8;
      od = d8; ot = mtid8;
      @(posedge clk);
      cyc++;
      if (ov) begin
        checks++;
        if (od !== model8(av[n_out], bv[n_out], mv[n_out]) || ot !== 4'(n_out + 1)) begin
          errors++; $display("FAIL b2b_result%0d: got data %0d tid %0d expected %0d %0d", n_out, od, ot,
                             model8(av[n_out], bv[n_out], mv[n_out]), n_out + 1);
        end
        n_out++;
      end
      if (hs) begin hs_cyc[idx] = cyc; idx++; end
      @(negedge clk);
      if (hs) begin
        if (idx < 3) begin
          a8 = 8'(av[idx]); b8 = 8'(bv[idx]); m8 = 8'(mv[idx]); tid8 = 4'(idx + 1);
        end else sv8 = 1'b0;
      end
    end
    sv8 = 1'b0;
    mr8 = 1'b0;
    checks++; if (n_out != 3 || idx != 3) begin
      errors++; $display("FAIL b2b_timeout: got %0d results %0d accepts expected 3 3", n_out, idx);
    end else begin
      checks++; if (hs_cyc[1] - hs_cyc[0] != 10 || hs_cyc[2] - hs_cyc[1] != 10) begin
        errors++; $display("FAIL b2b_interval: got %0d %0d expected 10 10",
                           hs_cyc[1] - hs_cyc[0], hs_cyc[2] - hs_cyc[1]);
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] d, exp; logic [3:0] t, tid; logic e, sra, mva; int lat, a, b, m;
    for (int n = 0; n < 16; n++) begin
      m = int'($urandom_range(1, 255));
      a = int'($urandom_range(0, m - 1));
      b = int'($urandom_range(0, m - 1));
      tid = 4'($urandom);
      exp = model8(a, b, m);
      do_op8(8'(a), 8'(b), 8'(m), tid, d, t, e, lat);
      checks++; if (d !== exp || t !== tid || e !== 1'b0 || lat !== 8) begin
        errors++; $display("FAIL random%0d: got data %0d tid %0d err %b lat %0d expected %0d %0d 0 8 (a=%0d b=%0d m=%0d)",
                           n, d, t, e, lat, exp, tid, a, b, m);
      end
      release8(sra, mva);
    end
  endtask

  task automatic test_operand_check;
    logic [7:0] d; logic [3:0] t; logic e, sra, mva; int lat;
    do_op8(8'd5, 8'd3, 8'd0, 4'd6, d, t, e, lat);
    checks++; if (lat !== 8 || t !== 4'd6 || e !== CHK_EN) begin
      errors++; $display("FAIL opchk_m0: got lat %0d tid %0d err %b expected 8 6 %b", lat, t, e, CHK_EN);
    end
    if (CHK_EN) begin
      checks++; if (d !== 8'd0) begin errors++; $display("FAIL opchk_m0_data: got %0d expected 0", d); end
    end
    release8(sra, mva);
    do_op8(8'd12, 8'd3, 8'd11, 4'd7, d, t, e, lat);
    checks++; if (lat !== 8 || t !== 4'd7 || e !== CHK_EN) begin
      errors++; $display("FAIL opchk_range: got lat %0d tid %0d err %b expected 8 7 %b", lat, t, e, CHK_EN);
    end
    if (CHK_EN) begin
      checks++; if (d !== 8'd0) begin errors++; $display("FAIL opchk_range_data: got %0d expected 0", d); end
    end
    release8(sra, mva);
  endtask

  task automatic test_w64;
    logic [63:0] m, a, b, d, exp; logic [3:0] t; int lat;
    m = 64'hFFFF_FFFF_FFFF_FFC5;
    do_op64(m - 1, m - 1, m, 4'd10, d, t, lat);
    checks++; if (d !== 64'd1 || t !== 4'd10 || lat !== 64) begin
      errors++; $display("FAIL w64_max: got data %0h tid %0d lat %0d expected 1 10 64", d, t, lat);
    end
    do_op64(64'd0, m - 1, m, 4'd11, d, t, lat);
    checks++; if (d !== 64'd0 || t !== 4'd11) begin
      errors++; $display("FAIL w64_zero: got data %0h tid %0d expected 0 11", d, t);
    end
    for (int n = 0; n < 3; n++) begin
      m = {$urandom, $urandom} | 64'd1;
      a = {$urandom, $urandom} % m;
      b = {$urandom, $urandom} % m;
      exp = model64(a, b, m);
      do_op64(a, b, m, 4'(n), d, t, lat);
      checks++; if (d !== exp || t !== 4'(n) || lat !== 64) begin
        errors++; $display("FAIL w64_random%0d: got data %0h lat %0d expected %0h 64", n, d, lat, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_example();
    test_reset_mid();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_operand_check();
    test_w64();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_mult_interleaved.md
Name: mod_mult_interleaved

Overview:
- Iterative interleaved (shift-add-reduce) modular multiplier: result = (a * b) mod m, WIDTH-bit operands.
- Successor to the multiply-then-divide modular multiplier; the full 2*WIDTH product is never formed.
- All three operands arrive on one AXI-stream style beat with a single handshake.
- Building block for the ElGamal modular-exponentiation datapath; a tag field lets the exponentiation controller match results to requests.

Parameters:
- WIDTH, 64, operand, modulus and result width in bits (>= 4).
- TAG_W, 4, width of the request tag passed through to the result.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_a_tdata  in  WIDTH  multiplier a.
- s_b_tdata  in  WIDTH  multiplicand b.
- s_m_tdata  in  WIDTH  modulus m.
- s_tid  in  TAG_W  request tag.
- s_tvalid  in  1  request beat valid.
- s_tready  out  1  block can accept a request.
- m_tdata  out  WIDTH  result (a*b) mod m.
- m_tid  out  TAG_W  tag of the request that produced m_tdata.
- m_err  out  1  operand error flag (see Optional Feature).
- m_tvalid  out  1  result valid.
- m_tready  in  1  downstream accepts the result.

Behaviour:
- Reset, sampled on the clock edge:
  - state = IDLE; m_tvalid = 0; m_tdata = 0; m_tid = 0; m_err = 0; internal accumulator P = 0.
  - s_tready = 0 while rst is high, and 1 in the first IDLE cycle after rst falls.
- s_tready is driven combinationally: high only in IDLE and not in reset.
- States:
  - IDLE:
    - s_tready = 1, m_tvalid = 0.
    - On s_tvalid & s_tready: latch a, b, m, tid; P <= 0; bit counter i <= WIDTH-1; go to RUN.
  - RUN:
    - One bit of a per cycle, MSB first: T = 2P + (a[i] ? b : 0); if T >= m then T -= m; if T >= m then T -= m; P <= T.
    - P and T are WIDTH+2 bits wide; no truncation occurs for a, b < m.
    - On the edge where i == 0: m_tdata <= final T, m_tid <= latched tag, m_tvalid <= 1; go to DONE. Otherwise i <= i-1.
  - DONE:
    - m_tvalid = 1; m_tdata, m_tid and m_err are held stable while m_tready = 0.
    - On m_tvalid & m_tready: m_tvalid <= 0; go to IDLE.
    - m_tdata is not cleared; it holds the last result.
- Latency and throughput:
  - m_tvalid is observed high exactly WIDTH edges after the input handshake edge.
  - The result leaves on edge WIDTH+1 at the earliest; the next request is accepted on edge WIDTH+2.
  - Minimum initiation interval is WIDTH+2 cycles. There is no overlap of requests.
- Inputs during RUN/DONE are ignored (s_tready = 0). The upstream must hold its beat until the handshake.
- Result is exact for 0 <= a, b < m and m >= 1. Special cases:
  - m = 1 gives 0.
  - a = 0 or b = 0 gives 0.
- rst asserted in RUN or DONE aborts the operation:
  - next edge state = IDLE, m_tvalid = 0, outputs return to reset values;
  - the in-flight result is discarded and no partial result is ever emitted.
- Simultaneous rst and handshake: rst wins; the request is not accepted.

Optional Feature:
- Macro: MOD_MULT_OPERAND_CHECK_EN.
- Defined:
  - At input handshake, latch err = (m == 0) | (a >= m) | (b >= m).
  - The operation still runs the full WIDTH cycles, so timing is unchanged.
  - If err: m_tdata = 0 and m_err = 1 with the result. Otherwise m_err = 0.
- Undefined:
  - No comparators are built; m_err is tied to 0.
  - Out-of-range operands yield an unspecified m_tdata with identical handshake timing.

Test Plan:
- WIDTH=8: a=7, b=9, m=11, tid=3 -> m_tvalid high exactly 8 edges after handshake; m_tdata=8, m_tid=3, m_err=0.
- WIDTH=64, m=2^64-59, a=b=m-1 -> m_tdata=1. With a=0, b=m-1 -> m_tdata=0.
- Backpressure:
  - Stimulus: hold m_tready=0 for 5 cycles after m_tvalid rises.
  - Required: m_tdata/m_tid stable and s_tready=0 throughout; after release, s_tready=1 on the cycle after the output handshake.
- Back-to-back, WIDTH=8, s_tvalid and m_tready held high:
  - Stimulus: tids 1, 2, 3 with (5,6,7), (10,10,13), (0,200,251).
  - Required: results 2, 9, 0 with matching tids; handshakes exactly 10 cycles apart.
- Reset mid-operation:
  - Stimulus: rst pulsed for 1 cycle 4 edges into RUN.
  - Required: next cycle m_tvalid=0, m_tdata=0, s_tready=1; no result appears for that request; a following request computes correctly.
- With MOD_MULT_OPERAND_CHECK_EN, WIDTH=8:
  - m=0 -> m_err=1, m_tdata=0, same latency.
  - a=12, b=3, m=11 -> m_err=1.
  - Without the macro, the same stimuli give m_err=0 and correct timing.
